// File: rtl/link_dec_pkg.sv
// Shared definitions for the link receive-side decoder.
// Code/one-hot widths and the code-to-one-hot mapping.
package link_dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  // Binary code k maps to a one-hot word with only bit k set.
  function automatic logic [ONEHOT_W-1:0] code_to_onehot(
    input logic [CODE_W-1:0] c
  );
    logic [ONEHOT_W-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/link_dec_fifo.sv
// Synchronous FIFO holding received codes.
// Extra pointer bit separates full from empty.
module link_dec_fifo
  import link_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CODE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_ptr_lo_eq;

  assign w_ptr_lo_eq = (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty     = (r_wptr == r_rptr);
  assign o_full      = w_ptr_lo_eq && (r_wptr[AW] != r_rptr[AW]);
  assign o_level     = r_wptr - r_rptr;
  assign o_data      = r_mem[r_rptr[AW-1:0]];

  // Advance pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/link_decoder.sv
// Receive-end decoder: strobed 3-bit code to one-hot,
// buffered and delivered over valid/ready.
module link_decoder
  import link_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_a3value,
  input  logic                   in_a2value,
  input  logic                   in_a1value,
  input  logic                   in_a0value,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [ONEHOT_W-1:0]    dec_y,
  output logic [CODE_W-1:0]      dec_code,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   clr_err,
  output logic [CNT_W-1:0]       sym_count
);

  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_full;
  logic              w_empty;
  logic [CODE_W-1:0] w_head;
  logic [CODE_W-1:0] w_in_code;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_xfer;

  assign w_in_code = {in_a2value, in_a1value, in_a0value};

  // Output register refills whenever it is free or draining.
  assign w_pop  = !w_empty && (!r_valid || dec_ready);
  assign w_push = in_a3value && (!w_full || w_pop);
  assign w_drop = in_a3value && !w_push;
  assign w_xfer = r_valid && dec_ready;

  link_dec_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in_code),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Output stage: load from head, clear when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_code  <= w_head;
    end else if (dec_ready) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end
  end

  // Sticky overflow; a drop outranks clr_err.
  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_err) r_ovf <= 1'b0;
  end

  // Delivered-symbol counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_xfer && !(&r_cnt))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign dec_valid = r_valid;
  assign dec_code  = r_valid ? r_code : '0;
  assign dec_y     = r_valid ? code_to_onehot(r_code) : '0;
  assign overflow  = r_ovf;
  assign sym_count = r_cnt;

endmodule

// File: tb/tb_link_decoder.sv
// Self-checking bench for link_decoder.
// Scoreboard of accepted codes checked at each handshake.
module tb_link_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a3 = 1'b0, a2 = 1'b0;
  logic       a1 = 1'b0, a0 = 1'b0;
  logic       dec_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic       dec_valid;
  logic [7:0] dec_y;
  logic [2:0] dec_code;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [15:0] sym_count;

  logic       s_valid;
  logic [7:0] s_y;
  logic [2:0] s_code;
  logic [2:0] s_level;
  logic       s_ovf;
  logic [3:0] s_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] sb [$];
  logic [2:0] exp_c;
  logic [7:0] exp_y;
  logic [7:0] one = 8'd1;

  always #5 clk = ~clk;

  link_decoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_a3value (a3),
    .in_a2value (a2),
    .in_a1value (a1),
    .in_a0value (a0),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_y      (dec_y),
    .dec_code   (dec_code),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_err    (clr_err),
    .sym_count  (sym_count)
  );

  link_decoder #(.DEPTH(4), .CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_a3value (a3),
    .in_a2value (a2),
    .in_a1value (a1),
    .in_a0value (a0),
    .dec_valid  (s_valid),
    .dec_ready  (dec_ready),
    .dec_y      (s_y),
    .dec_code   (s_code),
    .fifo_level (s_level),
    .overflow   (s_ovf),
    .clr_err    (clr_err),
    .sym_count  (s_count)
  );

  // Handshake monitor: every delivery pops the scoreboard.
  always @(negedge clk) begin
    if (dec_valid && dec_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: got code %0d, expected none",
                 dec_code);
      end else begin
        exp_c = sb.pop_front();
        exp_y = one << exp_c;
        if (dec_code !== exp_c || dec_y !== exp_y) begin
          n_bad++;
          $display("FAIL sb_data: got %0d/%b, expected %0d/%b",
                   dec_code, dec_y, exp_c, exp_y);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] c);
    a3 = s;
    {a2, a1, a0} = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0);
    dec_ready = 1'b0;
    clr_err = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    n_cmp++;
    if (dec_valid !== 1'b0 || dec_y !== 8'h00 ||
        dec_code !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_out: v=%b y=%b c=%0d, expected 0",
               dec_valid, dec_y, dec_code);
    end
    n_cmp++;
    if (fifo_level !== 3'd0 || overflow !== 1'b0 ||
        sym_count !== 16'd0 || s_count !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_state: lvl=%0d ovf=%b cnt=%0d/%0d, expected 0",
               fifo_level, overflow, sym_count, s_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    dec_ready = 1'b1;
    drive(1'b1, 3'd5);
    sb.push_back(3'd5);
    step();
    n_cmp++;
    if (dec_valid !== 1'b0 || fifo_level !== 3'd1) begin
      n_bad++;
      $display("FAIL single_lat: v=%b lvl=%0d, expected 0/1",
               dec_valid, fifo_level);
    end
    drive(1'b0, 3'd0);
    step();
    n_cmp++;
    if (dec_valid !== 1'b1 || dec_y !== 8'b00100000 ||
        dec_code !== 3'd5) begin
      n_bad++;
      $display("FAIL single_out: v=%b y=%b c=%0d, expected 1/00100000/5",
               dec_valid, dec_y, dec_code);
    end
    step();
    n_cmp++;
    if (dec_valid !== 1'b0 || sym_count !== 16'd1 ||
        fifo_level !== 3'd0) begin
      n_bad++;
      $display("FAIL single_done: v=%b cnt=%0d lvl=%0d, expected 0/1/0",
               dec_valid, sym_count, fifo_level);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, c[2:0]);
      if (c < 5) sb.push_back(c[2:0]);
      step();
    end
    drive(1'b0, 3'd0);
    n_cmp++;
    if (dec_valid !== 1'b1 || dec_code !== 3'd0 ||
        fifo_level !== 3'd4 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_hold: v=%b c=%0d lvl=%0d ovf=%b, expected 1/0/4/1",
               dec_valid, dec_code, fifo_level, overflow);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (dec_valid !== 1'b0 || sym_count !== 16'd5 ||
        fifo_level !== 3'd0) begin
      n_bad++;
      $display("FAIL fill_drain: v=%b cnt=%0d lvl=%0d, expected 0/5/0",
               dec_valid, sym_count, fifo_level);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd3);
      sb.push_back(3'd3);
      step();
    end
    n_cmp++;
    if (fifo_level !== 3'd4) begin
      n_bad++;
      $display("FAIL full_lvl: lvl=%0d, expected 4", fifo_level);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd3);
      sb.push_back(3'd3);
      step();
      n_cmp++;
      if (fifo_level !== 3'd4 || dec_y !== 8'b00001000 ||
          overflow !== 1'b0 || dec_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL full_pp[%0d]: lvl=%0d y=%b ovf=%b v=%b",
                 i, fifo_level, dec_y, overflow, dec_valid);
      end
    end
    drive(1'b0, 3'd0);
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (dec_valid !== 1'b0 || sym_count !== 16'd15) begin
      n_bad++;
      $display("FAIL full_drain: v=%b cnt=%0d, expected 0/15",
               dec_valid, sym_count);
    end
  endtask

  task automatic test_clr_err();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd1);
      if (i < 5) sb.push_back(3'd1);
      step();
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: ovf=%b, expected 1", overflow);
    end
    drive(1'b1, 3'd2);
    clr_err = 1'b1;
    step();
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_collide: ovf=%b, expected 1", overflow);
    end
    drive(1'b0, 3'd0);
    step();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: ovf=%b, expected 0", overflow);
    end
    clr_err = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (dec_valid !== 1'b0 || sym_count !== 16'd5) begin
      n_bad++;
      $display("FAIL ovf_drain: v=%b cnt=%0d, expected 0/5",
               dec_valid, sym_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd6);
      step();
    end
    drive(1'b0, 3'd0);
    n_cmp++;
    if (dec_valid !== 1'b1 || fifo_level !== 3'd3) begin
      n_bad++;
      $display("FAIL mid_pre: v=%b lvl=%0d, expected 1/3",
               dec_valid, fifo_level);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (dec_valid !== 1'b0 || dec_y !== 8'h00 ||
        dec_code !== 3'd0 || fifo_level !== 3'd0 ||
        overflow !== 1'b0 || sym_count !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_rst: v=%b y=%b c=%0d lvl=%0d ovf=%b cnt=%0d",
               dec_valid, dec_y, dec_code, fifo_level,
               overflow, sym_count);
    end
    dec_ready = 1'b1;
    drive(1'b1, 3'd7);
    sb.push_back(3'd7);
    step();
    drive(1'b0, 3'd0);
    step();
    n_cmp++;
    if (dec_valid !== 1'b1 || dec_y !== 8'b10000000) begin
      n_bad++;
      $display("FAIL mid_post: v=%b y=%b, expected 1/10000000",
               dec_valid, dec_y);
    end
    step();
    n_cmp++;
    if (dec_valid !== 1'b0 || sym_count !== 16'd1) begin
      n_bad++;
      $display("FAIL mid_done: v=%b cnt=%0d, expected 0/1",
               dec_valid, sym_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i[2:0]);
      sb.push_back(i[2:0]);
      step();
    end
    drive(1'b0, 3'd0);
    step();
    step();
    n_cmp++;
    if (sym_count !== 16'd20 || s_count !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_cnt: cnt16=%0d cnt4=%0d, expected 20/15",
               sym_count, s_count);
    end
    n_cmp++;
    if (dec_valid !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_end: v=%b ovf=%b, expected 0/0",
               dec_valid, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_clr_err();
    test_reset_mid();
    test_saturation();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_left: %0d undelivered, expected 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
